// File: rtl/spi_frame_ctrl_if.sv
// Bus between spi_frame_ctrl, the SPI byte source and the parameter register file.
// The slave modport is the controller's view; master is the view of whatever drives it.
interface spi_frame_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_W     = 5,
    parameter int DATA_BYTES = 3
);
    logic [WIDTH-1:0]            byte_in;
    logic                        byte_valid;
    logic                        csn;
    logic                        wr_en;
    logic [ADDR_W-1:0]           wr_addr;
    logic [WIDTH*DATA_BYTES-1:0] wr_data;
    logic [ADDR_W-1:0]           rd_addr;
    logic [WIDTH*DATA_BYTES-1:0] rd_data;
    logic [WIDTH-1:0]            tx_byte;
    logic                        frame_err;
    logic                        busy;

    modport master (
        output byte_in, byte_valid, csn, rd_data,
        input  wr_en, wr_addr, wr_data, rd_addr, tx_byte, frame_err, busy
    );

    modport slave (
        input  byte_in, byte_valid, csn, rd_data,
        output wr_en, wr_addr, wr_data, rd_addr, tx_byte, frame_err, busy
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Turns the SPI byte stream into framed register writes and auto-incrementing reads.
// Header byte: MSB selects write, low ADDR_W bits give the start address, the rest must be zero.
module spi_frame_ctrl #(
    parameter int WIDTH      = 8,
    parameter int ADDR_W     = 5,
    parameter int DATA_BYTES = 3
) (
    input logic             clk,
    input logic             rst,
    spi_frame_ctrl_if.slave bus
);
    localparam int WORD_W = WIDTH * DATA_BYTES;
    localparam int CNT_W  = $clog2(DATA_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BYTES - 1);

    typedef enum logic [2:0] {IDLE, HDR, WDATA, RDATA, DRAIN} state_t;

    state_t            state;
    logic              byte_valid_q;
    logic              accept;
    logic              last_byte;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] asm_word;
    logic [WORD_W-1:0] rd_shift;
    logic              load_pend;

    logic              wr_en_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [WORD_W-1:0] wr_data_r;
    logic [ADDR_W-1:0] rd_addr_r;
    logic [WIDTH-1:0]  tx_byte_r;
    logic              frame_err_r;

    assign accept    = bus.byte_valid & ~byte_valid_q;
    assign last_byte = accept && (cnt == LAST);

    assign bus.wr_en     = wr_en_r;
    assign bus.wr_addr   = wr_addr_r;
    assign bus.wr_data   = wr_data_r;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.tx_byte   = tx_byte_r;
    assign bus.frame_err = frame_err_r;
    assign bus.busy      = (state != IDLE);

    // Read words take two cycles to appear on tx_byte: rd_addr settles, then the
    // combinational rd_data is captured while load_pend is set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_valid_q <= 1'b0;
            cnt          <= '0;
            addr         <= '0;
            asm_word     <= '0;
            rd_shift     <= '0;
            load_pend    <= 1'b0;
            wr_en_r      <= 1'b0;
            wr_addr_r    <= '0;
            wr_data_r    <= '0;
            rd_addr_r    <= '0;
            tx_byte_r    <= '0;
            frame_err_r  <= 1'b0;
        end else begin
            byte_valid_q <= bus.byte_valid;
            wr_en_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    load_pend <= 1'b0;
                    if (!bus.csn) state <= HDR;
                end
                HDR: begin
                    if (bus.csn) begin
                        state <= IDLE;
                    end else if (accept) begin
                        cnt <= '0;
                        if (bus.byte_in[WIDTH-2:ADDR_W] != '0) begin
                            frame_err_r <= 1'b1;
                            state       <= DRAIN;
                        end else if (bus.byte_in[WIDTH-1]) begin
                            addr  <= bus.byte_in[ADDR_W-1:0];
                            state <= WDATA;
                        end else begin
                            rd_addr_r <= bus.byte_in[ADDR_W-1:0];
                            load_pend <= 1'b1;
                            state     <= RDATA;
                        end
                    end
                end
                // A final byte arriving with the csn rise still completes its word.
                WDATA: begin
                    if (last_byte) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= addr;
                        wr_data_r <= {asm_word[WORD_W-WIDTH-1:0], bus.byte_in};
                        addr      <= addr + ADDR_W'(1);
                        cnt       <= '0;
                    end else if (accept) begin
                        asm_word <= {asm_word[WORD_W-WIDTH-1:0], bus.byte_in};
                        cnt      <= cnt + CNT_W'(1);
                    end
                    if (bus.csn) begin
                        state       <= IDLE;
                        frame_err_r <= ((cnt != '0) || accept) && !last_byte;
                    end
                end
                RDATA: begin
                    if (bus.csn) begin
                        state <= IDLE;
                    end else if (load_pend) begin
                        load_pend <= 1'b0;
                        tx_byte_r <= bus.rd_data[WORD_W-1 -: WIDTH];
                        rd_shift  <= bus.rd_data << WIDTH;
                    end else if (accept) begin
                        if (cnt == LAST) begin
                            cnt       <= '0;
                            rd_addr_r <= rd_addr_r + ADDR_W'(1);
                            load_pend <= 1'b1;
                        end else begin
                            cnt       <= cnt + CNT_W'(1);
                            tx_byte_r <= rd_shift[WORD_W-1 -: WIDTH];
                            rd_shift  <= rd_shift << WIDTH;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.csn) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/spi_frame_ctrl.md
Name: spi_frame_ctrl

Overview:
Command sequencer behind spi_slave. It turns the byte stream (recv/output_valid) from the MCU into framed register transactions for the synth parameter register file. Write frames become single-cycle write strobes with assembled data words; read frames fetch a register and feed its bytes back through spi_slave's send. Address auto-increments within a frame, so the MCU can burst-load voice parameters.

Parameters:
WIDTH, 8, SPI byte width; must match spi_slave WIDTH
ADDR_W, 5, register address width; must be ≤ WIDTH-2
DATA_BYTES, 3, bytes per register word, MSB first

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
byte_in  in  WIDTH  received byte (spi_slave recv)
byte_valid  in  1  spi_slave output_valid; level or pulse
csn  in  1  chip select, already synchronized to clk, high = deselected
wr_en  out  1  one-cycle register write strobe
wr_addr  out  ADDR_W  write address, valid with wr_en
wr_data  out  WIDTH*DATA_BYTES  write data, valid with wr_en
rd_addr  out  ADDR_W  read address to register file
rd_data  in  WIDTH*DATA_BYTES  register file data, combinational from rd_addr
tx_byte  out  WIDTH  byte for spi_slave send
frame_err  out  1  one-cycle pulse on a malformed or aborted frame
busy  out  1  high while a frame is open (state ≠ IDLE)

Behaviour:
- Reset (async, any state): state IDLE. wr_en, wr_addr, wr_data, rd_addr, tx_byte, frame_err, byte counter, and the byte_valid edge register all go to 0. busy goes to 0.
- Byte acceptance: a byte is accepted on the clk edge where byte_valid=1 and byte_valid_q=0 (internal rising-edge detect). A level held for N cycles counts once.
- Header byte:
  - bit WIDTH-1 = 1 means write, 0 means read.
  - bits ADDR_W-1:0 = start address.
  - bits WIDTH-2:ADDR_W are reserved and must be 0.
- States:
  - IDLE: on csn=0 go to HDR next cycle.
  - HDR: the accepted byte is decoded.
    - Reserved bits nonzero: frame_err pulse, go to DRAIN.
    - Write: latch address, clear counter, go to WDATA.
    - Read: rd_addr=addr at t+1; tx_byte=rd_data MSB byte at t+2; go to RDATA.
  - WDATA: shift accepted bytes into the assembly register MSB first.
    - On the DATA_BYTES-th byte (accepted cycle t): wr_en=1, wr_addr and wr_data valid in cycle t+1.
    - Then address += 1 (wraps mod 2^ADDR_W), counter clears, stay in WDATA (burst).
  - RDATA: each accepted byte (content ignored) advances tx_byte to the next byte of the latched word one cycle later.
    - After the last byte: rd_addr += 1 (wraps), the new word is latched, and tx_byte becomes its MSB byte two cycles after acceptance.
  - DRAIN: ignore all bytes; no wr_en.
- csn rising, any non-IDLE state: return to IDLE next cycle.
  - In WDATA with counter > 0 (partial word): the word is discarded, no wr_en, frame_err pulses once.
  - In HDR, RDATA, DRAIN, or WDATA with counter = 0: no error.
- Simultaneous csn rise and acceptance of the final write byte: the write completes (wr_en pulses) and there is no error.
- wr_addr and wr_data hold their last values between strobes. tx_byte holds between updates.
- There is no back-pressure; the register file must accept wr_en every cycle.

Test Plan:
- Write: csn=0, bytes 0x83, 0x12, 0x34, 0x56, csn=1 -> exactly one wr_en pulse with wr_addr=3 and wr_data=0x123456; frame_err never asserts; busy falls one cycle after csn rises.
- Burst wrap: header 0x9F, then 0x01…0x06 -> two wr_en pulses: addr 31 data 0x010203, then addr 0 data 0x040506.
- Read: header 0x05 with rd_data(5)=0xABCDEF and rd_data(6)=0x112233, then 3 dummy bytes -> tx_byte sequence 0xAB, 0xCD, 0xEF; after the third dummy byte, rd_addr=6 and tx_byte=0x11; wr_en never asserts.
- Abort: 0x81, 0xAA, csn=1 -> no wr_en, one frame_err pulse, state IDLE; a following frame 0x81, 1, 2, 3 writes 0x010203 to addr 1 normally.
- Reserved bits: header 0xE1, then 3 bytes -> frame_err pulse after the header, no wr_en for the whole frame, busy remains high until csn rises.
- Edge detect and reset:
  - byte_valid held high for 4 cycles per byte -> same result as the write test.
  - rst asserted mid-WDATA -> all outputs 0 immediately (async), no wr_en after release, and the next frame works.
